// File: rtl/bram_32k_arbiter.sv
// Two-master arbiter/sequencer for a single-port synchronous-read 32-bit block RAM.
// Instruction fetch (read-only) and data port (read/write) share the memory one access at a time.
module bram_32k_arbiter #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_arvalid,
    input  logic [ADDR_WIDTH-1:0] i_araddr,
    output logic                  i_arready,
    output logic [31:0]           i_rdata,
    output logic                  i_rvalid,
    input  logic                  i_rready,
    input  logic                  d_arvalid,
    input  logic [ADDR_WIDTH-1:0] d_araddr,
    output logic                  d_arready,
    output logic [31:0]           d_rdata,
    output logic                  d_rvalid,
    input  logic                  d_rready,
    input  logic                  d_awvalid,
    input  logic [ADDR_WIDTH-1:0] d_awaddr,
    output logic                  d_awready,
    input  logic [31:0]           d_wdata,
    input  logic [3:0]            d_wstrb,
    input  logic                  d_wvalid,
    output logic                  d_wready,
    output logic                  d_bvalid,
    input  logic                  d_bready,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RD_RESP = 2'd2,
        ST_WR_RESP = 2'd3
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_e      state_r, state_next_s;
    logic        last_grant_r, last_grant_next_s;
    logic        rd_port_r, rd_port_next_s;
    logic [31:0] i_rdata_r, d_rdata_r;
    logic        i_rvalid_r, d_rvalid_r, d_bvalid_r;

    logic        i_req_s, d_wr_req_s, d_req_s;
    logic        grant_i_s, grant_d_s;

    // Request decode and round-robin choice between the I and D ports
    always_comb begin
        i_req_s    = i_arvalid;
        d_wr_req_s = d_awvalid & d_wvalid;
        d_req_s    = d_arvalid | d_wr_req_s;
        grant_i_s  = 1'b0;
        grant_d_s  = 1'b0;
        if (i_req_s && d_req_s) begin
            // Both contend: the port that did not win last time goes now.
            grant_i_s = (last_grant_r == PORT_D);
            grant_d_s = (last_grant_r == PORT_I);
        end else begin
            grant_i_s = i_req_s;
            grant_d_s = d_req_s;
        end
    end

    // Next-state, handshake readys and memory pin drive
    always_comb begin
        state_next_s      = state_r;
        last_grant_next_s = last_grant_r;
        rd_port_next_s    = rd_port_r;
        i_arready         = 1'b0;
        d_arready         = 1'b0;
        d_awready         = 1'b0;
        d_wready          = 1'b0;
        mem_en            = 1'b0;
        mem_we            = 4'b0000;
        mem_addr          = {ADDR_WIDTH{1'b0}};
        mem_wdata         = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (grant_d_s && d_wr_req_s) begin
                    d_awready         = 1'b1;
                    d_wready          = 1'b1;
                    mem_en            = 1'b1;
                    mem_we            = d_wstrb;
                    mem_addr          = d_awaddr;
                    mem_wdata         = d_wdata;
                    last_grant_next_s = PORT_D;
                    state_next_s      = ST_WR_RESP;
                end else if (grant_d_s) begin
                    d_arready         = 1'b1;
                    mem_en            = 1'b1;
                    mem_addr          = d_araddr;
                    last_grant_next_s = PORT_D;
                    rd_port_next_s    = PORT_D;
                    state_next_s      = ST_RD_WAIT;
                end else if (grant_i_s) begin
                    i_arready         = 1'b1;
                    mem_en            = 1'b1;
                    mem_addr          = i_araddr;
                    last_grant_next_s = PORT_I;
                    rd_port_next_s    = PORT_I;
                    state_next_s      = ST_RD_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                state_next_s = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if ((rd_port_r == PORT_I) ? i_rready : d_rready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RD_RESP;
                end
            end
            ST_WR_RESP: begin
                if (d_bready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WR_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, arbitration history and registered response valids
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= PORT_D;
            rd_port_r    <= PORT_I;
            i_rvalid_r   <= 1'b0;
            d_rvalid_r   <= 1'b0;
            d_bvalid_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            last_grant_r <= last_grant_next_s;
            rd_port_r    <= rd_port_next_s;
            i_rvalid_r   <= (state_next_s == ST_RD_RESP) && (rd_port_next_s == PORT_I);
            d_rvalid_r   <= (state_next_s == ST_RD_RESP) && (rd_port_next_s == PORT_D);
            d_bvalid_r   <= (state_next_s == ST_WR_RESP);
        end
    end

    // Read data capture; each port's register only changes in its own RD_WAIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata_r <= 32'h0000_0000;
            d_rdata_r <= 32'h0000_0000;
        end else if (state_r == ST_RD_WAIT) begin
            if (rd_port_r == PORT_I) begin
                i_rdata_r <= mem_rdata;
            end else begin
                d_rdata_r <= mem_rdata;
            end
        end
    end

    assign i_rdata  = i_rdata_r;
    assign d_rdata  = d_rdata_r;
    assign i_rvalid = i_rvalid_r;
    assign d_rvalid = d_rvalid_r;
    assign d_bvalid = d_bvalid_r;

    bram_32k_arbiter_checker u_checker (
        .clk       (clk),
        .rst       (rst),
        .i_arready (i_arready),
        .d_arready (d_arready),
        .d_awready (d_awready),
        .d_wready  (d_wready),
        .i_rvalid  (i_rvalid),
        .d_rvalid  (d_rvalid),
        .d_bvalid  (d_bvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we)
    );

endmodule

// Protocol invariants of the arbiter: single grant, paired write readys, no access while busy.
module bram_32k_arbiter_checker (
    input logic       clk,
    input logic       rst,
    input logic       i_arready,
    input logic       d_arready,
    input logic       d_awready,
    input logic       d_wready,
    input logic       i_rvalid,
    input logic       d_rvalid,
    input logic       d_bvalid,
    input logic       mem_en,
    input logic [3:0] mem_we
);

    a_single_grant: assert property (@(posedge clk) disable iff (rst)
        $onehot0({i_arready, d_arready, d_awready}));

    a_write_ready_pair: assert property (@(posedge clk) disable iff (rst)
        d_awready == d_wready);

    a_we_needs_en: assert property (@(posedge clk) disable iff (rst)
        (mem_we != 4'b0000) |-> mem_en);

    a_single_response: assert property (@(posedge clk) disable iff (rst)
        $onehot0({i_rvalid, d_rvalid, d_bvalid}));

    a_no_access_while_busy: assert property (@(posedge clk) disable iff (rst)
        (i_rvalid || d_rvalid || d_bvalid) |-> !mem_en);

endmodule

// File: tb/tb_bram_32k_arbiter.sv
// Self-checking bench for bram_32k_arbiter: behavioural block RAM plus a transaction-level
// reference (byte-merged memory image and round-robin winner) driven by scenario tasks.
module tb_bram_32k_arbiter;

    localparam int AW = 15;

    logic          clk, rst;
    logic          i_arvalid, i_arready, i_rvalid, i_rready;
    logic [AW-1:0] i_araddr;
    logic [31:0]   i_rdata;
    logic          d_arvalid, d_arready, d_rvalid, d_rready;
    logic [AW-1:0] d_araddr, d_awaddr;
    logic [31:0]   d_rdata, d_wdata;
    logic          d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
    logic [3:0]    d_wstrb;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    logic model_last_d;

    logic [31:0]   mem_model [0:(1<<AW)-1];
    logic [31:0]   ref_mem   [0:(1<<AW)-1];
    logic          bd_en;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;

    bram_32k_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .d_awvalid(d_awvalid), .d_awaddr(d_awaddr), .d_awready(d_awready),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready),
        .d_bvalid(d_bvalid), .d_bready(d_bready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous-read RAM with a backdoor load port used only while the DUT is idle
    always @(posedge clk) begin
        if (bd_en) begin
            mem_model[bd_addr] <= bd_data;
        end else if (mem_en) begin
            mem_rdata <= mem_model[mem_addr];
            for (int n = 0; n < 4; n++)
                if (mem_we[n]) mem_model[mem_addr][8*n +: 8] <= mem_wdata[8*n +: 8];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        for (int n = 0; n < 4; n++) r[8*n +: 8] = strb[n] ? new_w[8*n +: 8] : old_w[8*n +: 8];
        return r;
    endfunction

    task automatic idle_inputs();
        i_arvalid = 1'b0; i_araddr = '0; i_rready = 1'b0;
        d_arvalid = 1'b0; d_araddr = '0; d_rready = 1'b0;
        d_awvalid = 1'b0; d_awaddr = '0; d_wvalid = 1'b0;
        d_wdata = 32'h0; d_wstrb = 4'h0; d_bready = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk); bd_en = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
        @(negedge clk); bd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        model_last_d = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; idle_inputs();
        @(negedge clk); #1;
        checks++;
        if ({i_rvalid, d_rvalid, d_bvalid, i_arready, d_arready, d_awready, d_wready, mem_en} !== 8'h00) begin
            errors++; $display("FAIL reset_flags: got %b required 00000000",
                {i_rvalid, d_rvalid, d_bvalid, i_arready, d_arready, d_awready, d_wready, mem_en});
        end
        checks++;
        if (mem_we !== 4'b0000 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data: we=%b i_rdata=%h d_rdata=%h required 0", mem_we, i_rdata, d_rdata);
        end
        @(negedge clk); rst = 1'b0;
        model_last_d = 1'b1;
    endtask

    task automatic test_i_read();
        preload(15'h0010, 32'hDEADBEEF);
        @(negedge clk); i_arvalid = 1'b1; i_araddr = 15'h0010; i_rready = 1'b1; #1;
        checks++;
        if (i_arready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 15'h0010 || mem_we !== 4'b0000) begin
            errors++; $display("FAIL iread_accept: arready=%b en=%b addr=%h we=%b required 1 1 0010 0000",
                i_arready, mem_en, mem_addr, mem_we);
        end
        @(negedge clk); i_arvalid = 1'b0; #1;
        checks++;
        if (mem_en !== 1'b0 || i_rvalid !== 1'b0) begin
            errors++; $display("FAIL iread_wait: en=%b rvalid=%b required 0 0", mem_en, i_rvalid);
        end
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL iread_data: rvalid=%b rdata=%h d_rvalid=%b required 1 deadbeef 0",
                i_rvalid, i_rdata, d_rvalid);
        end
        @(negedge clk); i_rready = 1'b0; #1;
        checks++;
        if (i_rvalid !== 1'b0) begin
            errors++; $display("FAIL iread_done: rvalid=%b required 0", i_rvalid);
        end
        model_last_d = 1'b0;
    endtask

    task automatic test_write_strobe();
        preload(15'h0004, 32'hAABBCCDD);
        @(negedge clk);
        d_awvalid = 1'b1; d_wvalid = 1'b1; d_awaddr = 15'h0004;
        d_wdata = 32'h11223344; d_wstrb = 4'b0101; d_bready = 1'b1; #1;
        checks++;
        if (d_awready !== 1'b1 || d_wready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0101 ||
            mem_addr !== 15'h0004 || mem_wdata !== 32'h11223344) begin
            errors++; $display("FAIL write_accept: aw=%b w=%b en=%b we=%b addr=%h wdata=%h required 1 1 1 0101 0004 11223344",
                d_awready, d_wready, mem_en, mem_we, mem_addr, mem_wdata);
        end
        ref_mem[15'h0004] = merge(ref_mem[15'h0004], 32'h11223344, 4'b0101);
        @(negedge clk); d_awvalid = 1'b0; d_wvalid = 1'b0; #1;
        checks++;
        if (d_bvalid !== 1'b1) begin
            errors++; $display("FAIL write_bvalid: got %b required 1", d_bvalid);
        end
        @(negedge clk); d_bready = 1'b0;
        d_arvalid = 1'b1; d_araddr = 15'h0004; d_rready = 1'b1; #1;
        checks++;
        if (d_bvalid !== 1'b0 || d_arready !== 1'b1) begin
            errors++; $display("FAIL write_then_read: bvalid=%b arready=%b required 0 1", d_bvalid, d_arready);
        end
        @(negedge clk); d_arvalid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hAA22CC44) begin
            errors++; $display("FAIL write_readback: rvalid=%b rdata=%h required 1 aa22cc44", d_rvalid, d_rdata);
        end
        @(negedge clk); d_rready = 1'b0;
        model_last_d = 1'b1;
    endtask

    task automatic test_alternation();
        logic [AW-1:0] ia [8];
        logic [AW-1:0] da [8];
        logic [AW-1:0] ea;
        logic          exp_i;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            ia[k] = AW'($urandom_range(0, (1<<AW)-1));
            da[k] = AW'($urandom_range(0, (1<<AW)-1));
            preload(ia[k], $urandom);
            preload(da[k], $urandom);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            i_arvalid = 1'b1; d_arvalid = 1'b1; i_araddr = ia[k]; d_araddr = da[k];
            i_rready = 1'b1; d_rready = 1'b1; #1;
            exp_i = (k % 2 == 0);
            ea = exp_i ? ia[k] : da[k];
            checks++;
            if (i_arready !== exp_i || d_arready !== !exp_i || mem_addr !== ea) begin
                errors++; $display("FAIL alt_grant[%0d]: i=%b d=%b addr=%h required %b %b %h",
                    k, i_arready, d_arready, mem_addr, exp_i, !exp_i, ea);
            end
            @(negedge clk); #1;
            checks++;
            if (i_arready !== 1'b0 || d_arready !== 1'b0) begin
                errors++; $display("FAIL alt_busy[%0d]: i=%b d=%b required 0 0", k, i_arready, d_arready);
            end
            @(negedge clk); #1;
            checks++;
            if (i_rvalid !== exp_i || d_rvalid !== !exp_i ||
                (exp_i ? i_rdata : d_rdata) !== ref_mem[ea]) begin
                errors++; $display("FAIL alt_resp[%0d]: ivalid=%b dvalid=%b data=%h required %b %b %h",
                    k, i_rvalid, d_rvalid, exp_i ? i_rdata : d_rdata, exp_i, !exp_i, ref_mem[ea]);
            end
        end
        @(negedge clk); idle_inputs();
        model_last_d = 1'b1;
    endtask

    task automatic test_write_priority();
        logic [AW-1:0] a;
        logic [31:0]   wd;
        logic [3:0]    ws;
        for (int it = 0; it < 4; it++) begin
            a  = AW'($urandom_range(0, (1<<AW)-1));
            preload(a, $urandom);
            wd = $urandom;
            ws = (it == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            @(negedge clk);
            d_awvalid = 1'b1; d_wvalid = 1'b1; d_arvalid = 1'b1; d_awaddr = a; d_araddr = a;
            d_wdata = wd; d_wstrb = ws; d_bready = 1'b1; d_rready = 1'b1; #1;
            checks++;
            if (d_awready !== 1'b1 || d_wready !== 1'b1 || d_arready !== 1'b0 ||
                mem_en !== 1'b1 || mem_we !== ws) begin
                errors++; $display("FAIL wpri_grant[%0d]: aw=%b w=%b ar=%b en=%b we=%b required 1 1 0 1 %b",
                    it, d_awready, d_wready, d_arready, mem_en, mem_we, ws);
            end
            ref_mem[a] = merge(ref_mem[a], wd, ws);
            @(negedge clk); d_awvalid = 1'b0; d_wvalid = 1'b0; #1;
            checks++;
            if (d_bvalid !== 1'b1 || d_arready !== 1'b0) begin
                errors++; $display("FAIL wpri_bresp[%0d]: bvalid=%b ar=%b required 1 0", it, d_bvalid, d_arready);
            end
            @(negedge clk); #1;
            checks++;
            if (d_arready !== 1'b1 || mem_we !== 4'b0000 || mem_addr !== a) begin
                errors++; $display("FAIL wpri_read[%0d]: ar=%b we=%b addr=%h required 1 0000 %h",
                    it, d_arready, mem_we, mem_addr, a);
            end
            @(negedge clk); d_arvalid = 1'b0;
            @(negedge clk); #1;
            checks++;
            if (d_rvalid !== 1'b1 || d_rdata !== ref_mem[a]) begin
                errors++; $display("FAIL wpri_data[%0d]: rvalid=%b rdata=%h required 1 %h",
                    it, d_rvalid, d_rdata, ref_mem[a]);
            end
            @(negedge clk); idle_inputs();
        end
        model_last_d = 1'b1;
    endtask

    task automatic test_stall();
        logic [AW-1:0] a, b;
        a = AW'($urandom_range(0, (1<<AW)-1));
        b = AW'($urandom_range(0, (1<<AW)-1));
        preload(a, $urandom);
        preload(b, $urandom);
        @(negedge clk); d_arvalid = 1'b1; d_araddr = a; d_rready = 1'b0; #1;
        checks++;
        if (d_arready !== 1'b1) begin
            errors++; $display("FAIL stall_accept: d_arready=%b required 1", d_arready);
        end
        @(negedge clk); d_arvalid = 1'b0; i_arvalid = 1'b1; i_araddr = b; i_rready = 1'b1; #1;
        checks++;
        if (i_arready !== 1'b0) begin
            errors++; $display("FAIL stall_wait_block: i_arready=%b required 0", i_arready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++;
            if (d_rvalid !== 1'b1 || d_rdata !== ref_mem[a] || i_arready !== 1'b0 || mem_en !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d]: rvalid=%b rdata=%h i_arready=%b en=%b required 1 %h 0 0",
                    c, d_rvalid, d_rdata, i_arready, mem_en, ref_mem[a]);
            end
        end
        d_rready = 1'b1;
        @(negedge clk); d_rready = 1'b0; #1;
        checks++;
        if (i_arready !== 1'b1 || d_rvalid !== 1'b0 || mem_addr !== b) begin
            errors++; $display("FAIL stall_release: i_arready=%b d_rvalid=%b addr=%h required 1 0 %h",
                i_arready, d_rvalid, mem_addr, b);
        end
        @(negedge clk); i_arvalid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== ref_mem[b]) begin
            errors++; $display("FAIL stall_iread: rvalid=%b rdata=%h required 1 %h", i_rvalid, i_rdata, ref_mem[b]);
        end
        @(negedge clk); idle_inputs();
        model_last_d = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a, w;
        logic [31:0]   wd;
        a  = AW'($urandom_range(0, (1<<AW)-1));
        w  = AW'($urandom_range(0, (1<<AW)-1));
        wd = $urandom;
        preload(a, $urandom);
        preload(w, $urandom);
        @(negedge clk); i_arvalid = 1'b1; i_araddr = a; i_rready = 1'b0;
        @(negedge clk); i_arvalid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b1) begin
            errors++; $display("FAIL rstmid_rresp: i_rvalid=%b required 1", i_rvalid);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || d_bvalid !== 1'b0 || i_rdata !== 32'h0) begin
            errors++; $display("FAIL rstmid_rd_abort: iv=%b dv=%b bv=%b rdata=%h required 0 0 0 0",
                i_rvalid, d_rvalid, d_bvalid, i_rdata);
        end
        rst = 1'b0;
        @(negedge clk); d_awvalid = 1'b1; d_wvalid = 1'b1; d_awaddr = w; d_wdata = wd; d_wstrb = 4'b1111;
        d_bready = 1'b0; #1;
        checks++;
        if (d_awready !== 1'b1) begin
            errors++; $display("FAIL rstmid_waccept: d_awready=%b required 1", d_awready);
        end
        ref_mem[w] = wd;
        @(negedge clk); d_awvalid = 1'b0; d_wvalid = 1'b0; #1;
        checks++;
        if (d_bvalid !== 1'b1) begin
            errors++; $display("FAIL rstmid_bresp: d_bvalid=%b required 1", d_bvalid);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (d_bvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            errors++; $display("FAIL rstmid_wr_abort: bv=%b iv=%b dv=%b required 0 0 0", d_bvalid, i_rvalid, d_rvalid);
        end
        rst = 1'b0;
        @(negedge clk);
        i_arvalid = 1'b1; i_araddr = a; d_arvalid = 1'b1; d_araddr = w; i_rready = 1'b1; d_rready = 1'b1; #1;
        checks++;
        if (i_arready !== 1'b1 || d_arready !== 1'b0) begin
            errors++; $display("FAIL rstmid_first_grant: i=%b d=%b required 1 0", i_arready, d_arready);
        end
        @(negedge clk); i_arvalid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== ref_mem[a]) begin
            errors++; $display("FAIL rstmid_iread: rvalid=%b rdata=%h required 1 %h", i_rvalid, i_rdata, ref_mem[a]);
        end
        @(negedge clk); #1;
        checks++;
        if (d_arready !== 1'b1) begin
            errors++; $display("FAIL rstmid_d_grant: d_arready=%b required 1", d_arready);
        end
        @(negedge clk); d_arvalid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== wd) begin
            errors++; $display("FAIL rstmid_committed: rvalid=%b rdata=%h required 1 %h", d_rvalid, d_rdata, wd);
        end
        @(negedge clk); idle_inputs();
        model_last_d = 1'b1;
    endtask

    task automatic test_random_traffic();
        logic [AW-1:0] pool [8];
        logic          ri, rd, rw, win_d;
        logic [AW-1:0] ai, ad, aw, ea;
        logic [31:0]   wd, exp_data;
        logic [3:0]    ws;
        logic [2:0]    exp_rdy;
        int            dly;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            pool[k] = AW'($urandom_range(0, (1<<AW)-1));
            preload(pool[k], $urandom);
        end
        for (int it = 0; it < 40; it++) begin
            ri = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
            if (!ri && !rd && !rw) ri = 1'b1;
            ai = pool[$urandom_range(0, 7)]; ad = pool[$urandom_range(0, 7)]; aw = pool[$urandom_range(0, 7)];
            wd = $urandom; ws = 4'($urandom_range(0, 15));
            dly = $urandom_range(0, 3);
            if (ri && (rd || rw)) win_d = !model_last_d;
            else                  win_d = !ri;
            model_last_d = win_d;
            if (!win_d)      begin exp_rdy = 3'b100; ea = ai; end
            else if (rw)     begin exp_rdy = 3'b001; ea = aw; end
            else             begin exp_rdy = 3'b010; ea = ad; end
            @(negedge clk);
            i_arvalid = ri; i_araddr = ai; d_arvalid = rd; d_araddr = ad;
            d_awvalid = rw; d_wvalid = rw; d_awaddr = aw; d_wdata = wd; d_wstrb = ws; #1;
            checks++;
            if ({i_arready, d_arready, d_awready} !== exp_rdy || mem_addr !== ea ||
                mem_we !== (exp_rdy == 3'b001 ? ws : 4'b0000)) begin
                errors++; $display("FAIL rand_grant[%0d]: rdy=%b addr=%h we=%b required %b %h %b",
                    it, {i_arready, d_arready, d_awready}, mem_addr, mem_we, exp_rdy, ea,
                    (exp_rdy == 3'b001 ? ws : 4'b0000));
            end
            if (exp_rdy == 3'b001) ref_mem[aw] = merge(ref_mem[aw], wd, ws);
            exp_data = ref_mem[ea];
            @(negedge clk); idle_inputs();
            if (exp_rdy == 3'b001) begin
                for (int c = 0; c <= dly; c++) begin
                    #1;
                    checks++;
                    if (d_bvalid !== 1'b1 || i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                        errors++; $display("FAIL rand_bresp[%0d]: bv=%b iv=%b dv=%b required 1 0 0",
                            it, d_bvalid, i_rvalid, d_rvalid);
                    end
                    if (c < dly) @(negedge clk);
                end
                d_bready = 1'b1;
            end else begin
                @(negedge clk);
                for (int c = 0; c <= dly; c++) begin
                    #1;
                    checks++;
                    if (i_rvalid !== !win_d || d_rvalid !== win_d ||
                        (win_d ? d_rdata : i_rdata) !== exp_data) begin
                        errors++; $display("FAIL rand_rresp[%0d]: iv=%b dv=%b data=%h required %b %b %h",
                            it, i_rvalid, d_rvalid, win_d ? d_rdata : i_rdata, !win_d, win_d, exp_data);
                    end
                    if (c < dly) @(negedge clk);
                end
                if (win_d) d_rready = 1'b1;
                else       i_rready = 1'b1;
            end
            @(negedge clk); idle_inputs();
        end
    endtask

    initial begin
        rst = 1'b1; bd_en = 1'b0; bd_addr = '0; bd_data = 32'h0;
        idle_inputs();
        model_last_d = 1'b1;
        test_reset();
        test_i_read();
        test_write_strobe();
        test_alternation();
        test_write_priority();
        test_stall();
        test_reset_mid();
        test_random_traffic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_32k_arbiter.md
# bram_32k_arbiter

Two-master arbiter and sequencer for a single-port 32-bit block RAM. It shares one synchronous-read memory between the instruction-fetch port (read-only) and the data port (read/write) of the core, using AXI-lite-style valid/ready channels on both sides. It serialises accesses one at a time and drives the memory's enable, byte-write and address pins.

## Interface
- ADDR_WIDTH, 15, word-address width; memory depth is 2**ADDR_WIDTH words of 32 bits.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_arvalid  in  1  instruction read request.
- i_araddr  in  ADDR_WIDTH  instruction word address.
- i_arready  out  1  instruction address accepted this cycle.
- i_rdata  out  32  instruction read data.
- i_rvalid  out  1  instruction read data valid.
- i_rready  in  1  fetch unit consumes i_rdata.
- d_arvalid  in  1  data read request.
- d_araddr  in  ADDR_WIDTH  data read word address.
- d_arready  out  1  data read address accepted.
- d_rdata  out  32  data read data.
- d_rvalid  out  1  data read data valid.
- d_rready  in  1  data read data consumed.
- d_awvalid  in  1  data write address valid.
- d_awaddr  in  ADDR_WIDTH  data write word address.
- d_awready  out  1  write address accepted.
- d_wdata  in  32  write data.
- d_wstrb  in  4  byte enables; bit n enables byte lane n (bits 8n+7:8n).
- d_wvalid  in  1  write data valid.
- d_wready  out  1  write data accepted; asserted together with d_awready.
- d_bvalid  out  1  write response valid.
- d_bready  in  1  write response consumed.
- mem_en  out  1  memory access enable.
- mem_we  out  4  per-byte write enables; all zero for reads.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid one cycle after the mem_en cycle.

## Operation
- FSM states:
  - IDLE: arbitrate and accept one request.
  - RD_WAIT: memory read in flight.
  - RD_RESP: hold rvalid until rready.
  - WR_RESP: hold bvalid until bready.
- Request sources:
  - I-read: i_arvalid.
  - D-read: d_arvalid.
  - D-write: d_awvalid AND d_wvalid. A write whose address and data are not both valid is not a request.
- Within the data port, D-write beats D-read when both are pending.
- Between the I and D ports, arbitration is round-robin on a 1-bit last_grant register. When both ports request, the port not granted last wins. When only one port requests, it wins. last_grant updates on every accept.
- IDLE, on a grant:
  - The matching ready is asserted combinationally (i_arready, d_arready, or d_awready+d_wready together).
  - mem_en=1 and mem_addr is the granted address in the same cycle.
  - A write drives mem_we=d_wstrb and mem_wdata=d_wdata, then moves to WR_RESP.
  - A read drives mem_we=0, then moves to RD_WAIT.
- RD_WAIT: capture mem_rdata into the granted port's rdata register, then go to RD_RESP.
- RD_RESP: the granted rvalid is 1 and rdata is held stable. On rvalid&&rready, go to IDLE.
- WR_RESP: d_bvalid=1. On d_bvalid&&d_bready, go to IDLE.
- Outside the IDLE grant cycle, mem_en=0, mem_we=0 and all readys are 0. No new request is accepted while a response is outstanding.
- d_wstrb=0 is still a complete write transaction: mem_en=1, no bytes change, and bvalid is issued.
- Addresses are word addresses used unmodified. There is no wrap or range check; the full ADDR_WIDTH is passed through.

## Timing
- Reset values:
  - state=IDLE; last_grant=D, so the I port wins the first contention.
  - All rvalid/bvalid/ready outputs are 0; mem_en=0, mem_we=0.
  - i_rdata and d_rdata are 0.
- Reset asserted mid-transaction aborts it at the next edge. No response is issued and no further memory write is made. A write whose grant cycle already occurred has been committed to memory.
- Read latency: accept at cycle T, memory sampled at the T edge, capture at T+1, rvalid high from T+2. Minimum read period is 3 cycles when rready is held high.
- Write latency: accept and memory write at cycle T, bvalid high from T+1. Minimum write period is 2 cycles.
- Response held low (rready/bready=0) stalls the block indefinitely; rdata does not change while rvalid=1.
- Requesters may drop valid before being granted; nothing is latched before the grant.

## Test plan
- Reset, then an I-read of address 0x0010 holding word 0xDEADBEEF with i_rready=1 -> i_arready at T, mem_en=1 with mem_addr=0x0010 at T, i_rvalid=1 with i_rdata=0xDEADBEEF at T+2, IDLE at T+3.
- D-write to 0x0004 with wdata=0x11223344, wstrb=4'b0101, over old contents 0xAABBCCDD -> mem_we=4'b0101 at T, d_bvalid at T+1. A subsequent D-read of 0x0004 returns 0xAA22CC44.
- I-read and D-read continuously requesting from reset -> grants alternate I, D, I, D. Each response arrives on the correct port, and the other port's rvalid stays 0.
- D-write and D-read pending simultaneously, I idle -> write granted first (d_awready=d_wready=1, d_arready=0); read granted on the next IDLE.
- D-read with d_rready held low for 5 cycles -> d_rvalid and d_rdata stable throughout, i_arready stays 0 despite i_arvalid=1. The I port is granted the cycle after d_rready rises.
- rst pulsed during RD_RESP and during WR_RESP -> all valids 0 on the next cycle, state IDLE. The I port wins the first contention after reset.
